vote_logger: RTL and testbench
==============================

VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter COUNT_W, default 8: width of each per-candidate vote counter and of the display bus.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mode  input  1  0 = voting mode, 1 = result mode.
REQ-005 ballot_enable  input  1  single-cycle pulse from the debounced presiding-officer button; issues one ballot.
REQ-006 cand_vote  input  4  single-cycle debounced button pulses, bit i = candidate i.
REQ-007 ballot_ready  output  1  high while a ballot is issued and a vote is awaited.
REQ-008 vote_ack  output  1  one-cycle pulse confirming an accepted vote.
REQ-009 vote_reject  output  1  one-cycle pulse flagging a rejected multi-candidate press.
REQ-010 disp  output  COUNT_W  count shown in result mode.
REQ-011 disp_sel  output  2  index of the candidate whose count is on disp.
REQ-012 sat_flag  output  1  sticky; set when any counter has saturated.

Function
REQ-013 FSM states: IDLE and ARMED; the reset state is IDLE.
REQ-014 IDLE -> ARMED when ballot_enable=1 and mode=0; in every other case the FSM stays in IDLE.
REQ-015 ballot_ready = 1 exactly when the state is ARMED (Moore output).
REQ-016 In IDLE, any cand_vote activity is ignored: no count change, no ack, no reject.
REQ-017 In ARMED with mode=0 and exactly one cand_vote bit set at edge N:
  - count[i] increments at edge N;
  - state -> IDLE at edge N;
  - vote_ack is high during cycle N+1 only.
REQ-018 In ARMED with two or more cand_vote bits set at edge N:
  - no count change;
  - state remains ARMED;
  - vote_reject is high during cycle N+1 only.
REQ-019 In ARMED, ballot_enable is ignored; a ballot is never stacked and at most one vote is accepted per ballot.
REQ-020 In ARMED, mode=1 at an edge cancels the ballot: state -> IDLE, no count change, no ack.
REQ-021 Counters are COUNT_W bits unsigned and saturate at 2^COUNT_W-1:
  - a vote accepted at saturation leaves the count unchanged;
  - it still produces vote_ack;
  - it sets sat_flag.
REQ-022 sat_flag, once set, is cleared only by reset.
REQ-023 disp_sel register:
  - in mode=1, a cand_vote pulse with exactly one bit i set loads disp_sel=i at that edge;
  - multi-bit or zero pulses leave disp_sel unchanged;
  - in mode=1, cand_vote never alters any count.
REQ-024 disp = count[disp_sel] when mode=1, and 0 when mode=0 (combinational mux of registered values).
REQ-025 ballot_enable and cand_vote arriving on the same edge in IDLE: only the ballot is taken (-> ARMED); the vote is discarded.
REQ-026 Counts retain their values across mode changes; only reset clears them.

Reset
REQ-027 Reset at any edge, including mid-ballot, forces:
  - state = IDLE;
  - all counts = 0;
  - disp_sel = 0;
  - sat_flag = 0;
  - vote_ack = 0;
  - vote_reject = 0.
REQ-028 While reset is high, all inputs are ignored; the first edge after reset deassertion is treated as normal operation.

Verification
REQ-029 Basic vote: ballot_enable pulse; two cycles later cand_vote=4'b0100 -> ballot_ready 1 then 0, vote_ack one cycle; then mode=1 with cand_vote=4'b0100 -> disp_sel=2, disp=1.
REQ-030 Unarmed press: cand_vote=4'b0001 with no ballot issued -> count[0] stays 0 and vote_ack stays 0.
REQ-031 Double press:
  - ARMED, cand_vote=4'b0011 -> vote_reject pulse, ballot_ready stays 1;
  - then cand_vote=4'b0010 -> count[1]=1, vote_ack pulse.
REQ-032 Saturation: COUNT_W=2, four accepted votes for candidate 3 -> count[3]=3, sat_flag=1, and the fourth vote still pulses vote_ack.
REQ-033 Cancel and reset:
  - ARMED, then mode=1 -> ballot_ready=0 and counts unchanged;
  - accumulate count[0]=5, assert reset mid-ARMED -> all counts 0, state IDLE, disp=0 in mode=1.
REQ-034 Same-edge pulse: ballot_enable and cand_vote=4'b1000 together in IDLE -> ARMED, count[3]=0, no vote_ack.

Source files
------------

// File: rtl/vote_logger_if.sv
// Bundle of the ballot/vote handshake and result-display signals of the vote logger.
interface vote_logger_if #(
    parameter int COUNT_W = 8
);
    logic               mode;
    logic               ballot_enable;
    logic [3:0]         cand_vote;
    logic               ballot_ready;
    logic               vote_ack;
    logic               vote_reject;
    logic [COUNT_W-1:0] disp;
    logic [1:0]         disp_sel;
    logic               sat_flag;

    modport master (
        output mode, ballot_enable, cand_vote,
        input  ballot_ready, vote_ack, vote_reject, disp, disp_sel, sat_flag
    );

    modport slave (
        input  mode, ballot_enable, cand_vote,
        output ballot_ready, vote_ack, vote_reject, disp, disp_sel, sat_flag
    );
endinterface

// File: rtl/vote_logger.sv
// Four-candidate voting machine: one ballot per presiding-officer pulse, one accepted
// vote per ballot, saturating counters and a result-mode display mux.
module vote_logger #(
    parameter int COUNT_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    vote_logger_if.slave bus
);
    localparam logic [0:0]         S_IDLE  = 1'b0;
    localparam logic [0:0]         S_ARMED = 1'b1;
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [0:0]         r_state;
    logic [COUNT_W-1:0] r_count [4];
    logic [1:0]         r_disp_sel;
    logic               r_sat;
    logic               r_ack;
    logic               r_rej;

    logic               w_single;
    logic               w_multi;
    logic [1:0]         w_idx;

    always_comb begin
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cand_vote[i]) w_idx = i[1:0];
        end
    end

    assign w_single = $onehot(bus.cand_vote);
    assign w_multi  = (bus.cand_vote != 4'b0000) && !w_single;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_disp_sel <= 2'd0;
            r_sat      <= 1'b0;
            r_ack      <= 1'b0;
            r_rej      <= 1'b0;
            for (int i = 0; i < 4; i++) r_count[i] <= '0;
        end else begin
            r_ack <= 1'b0;
            r_rej <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A vote arriving with the ballot pulse is dropped; only the ballot counts.
                    if (bus.ballot_enable && !bus.mode) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (bus.mode) begin
                        r_state <= S_IDLE;
                    end else if (w_single) begin
                        if (r_count[w_idx] == CNT_MAX) r_sat <= 1'b1;
                        else                           r_count[w_idx] <= r_count[w_idx] + 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_multi) begin
                        r_rej <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (bus.mode && w_single) r_disp_sel <= w_idx;
        end
    end

    assign bus.ballot_ready = (r_state == S_ARMED);
    assign bus.vote_ack     = r_ack;
    assign bus.vote_reject  = r_rej;
    assign bus.disp_sel     = r_disp_sel;
    assign bus.sat_flag     = r_sat;
    assign bus.disp         = bus.mode ? r_count[r_disp_sel] : '0;
endmodule

// File: tb/tb_vote_logger.sv
// Bench for vote_logger: an 8-bit and a 2-bit instance share one stimulus stream and are
// checked against a ballot-level model, a directed vector table and hand sequences.
module tb_vote_logger;
    logic clock;
    logic reset;

    vote_logger_if #(.COUNT_W(8)) a();
    vote_logger_if #(.COUNT_W(2)) b();

    vote_logger #(.COUNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(a));
    vote_logger #(.COUNT_W(2)) dut_b (.clock(clock), .reset(reset), .bus(b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Ballot-level reference model, one slot per instance (0: 8-bit, 1: 2-bit).
    bit m_armed [2];
    int m_cnt   [2][4];
    int m_sel   [2];
    bit m_sat   [2];
    bit m_ack   [2];
    bit m_rej   [2];

    typedef struct {
        bit         rst;
        bit         mode;
        bit         be;
        logic [3:0] cv;
        bit         rdy;
        bit         ack;
        bit         rej;
        int         disp;
        int         sel;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit rst_i, input bit mode_i,
                              input bit be_i, input logic [3:0] cv_i);
        int n;
        int idx;
        int maxv;
        n    = $countones(cv_i);
        maxv = (k == 0) ? 255 : 3;
        idx  = 0;
        for (int i = 0; i < 4; i++) if (cv_i[i]) idx = i;
        m_ack[k] = 1'b0;
        m_rej[k] = 1'b0;
        if (rst_i) begin
            m_armed[k] = 1'b0;
            m_sel[k]   = 0;
            m_sat[k]   = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            return;
        end
        if (mode_i && n == 1) m_sel[k] = idx;
        if (!m_armed[k]) begin
            if (be_i && !mode_i) m_armed[k] = 1'b1;
        end else if (mode_i) begin
            m_armed[k] = 1'b0;
        end else if (n == 1) begin
            if (m_cnt[k][idx] == maxv) m_sat[k] = 1'b1;
            else                       m_cnt[k][idx] = m_cnt[k][idx] + 1;
            m_ack[k]   = 1'b1;
            m_armed[k] = 1'b0;
        end else if (n >= 2) begin
            m_rej[k] = 1'b1;
        end
    endtask

    task automatic cmp_model(input int k, input bit mode_i, input bit rdy, input bit ack,
                             input bit rej, input int disp, input int sel, input bit sat);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".ballot_ready"}, rdy, m_armed[k]);
        chk({p, ".vote_ack"}, ack, m_ack[k]);
        chk({p, ".vote_reject"}, rej, m_rej[k]);
        chk({p, ".disp_sel"}, sel, m_sel[k]);
        chk({p, ".sat_flag"}, sat, m_sat[k]);
        chk({p, ".disp"}, disp, mode_i ? m_cnt[k][m_sel[k]] : 0);
    endtask

    task automatic cycle(input bit rst_i, input bit mode_i, input bit be_i,
                         input logic [3:0] cv_i);
        reset           = rst_i;
        a.mode          = mode_i;
        a.ballot_enable = be_i;
        a.cand_vote     = cv_i;
        b.mode          = mode_i;
        b.ballot_enable = be_i;
        b.cand_vote     = cv_i;
        @(posedge clock);
        model_step(0, rst_i, mode_i, be_i, cv_i);
        model_step(1, rst_i, mode_i, be_i, cv_i);
        #1;
        cmp_model(0, mode_i, a.ballot_ready, a.vote_ack, a.vote_reject,
                  int'(a.disp), int'(a.disp_sel), a.sat_flag);
        cmp_model(1, mode_i, b.ballot_ready, b.vote_ack, b.vote_reject,
                  int'(b.disp), int'(b.disp_sel), b.sat_flag);
    endtask

    task automatic vote(input logic [3:0] cv_i);
        cycle(1'b0, 1'b0, 1'b1, 4'b0000);
        cycle(1'b0, 1'b0, 1'b0, cv_i);
    endtask

    initial begin
        logic [3:0] cv;
        int r;

        tbl[0]  = '{1, 0, 0, 4'b0000, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 4'b0001, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 4'b0001, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 4'b0000, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 4'b0000, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 4'b0000, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 4'b0100, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 4'b0000, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 4'b0100, 0, 0, 0, 1, 2};
        tbl[9]  = '{0, 0, 1, 4'b0000, 1, 0, 0, 0, 2};
        tbl[10] = '{0, 0, 0, 4'b0011, 1, 0, 1, 0, 2};
        tbl[11] = '{0, 0, 0, 4'b0000, 1, 0, 0, 0, 2};
        tbl[12] = '{0, 0, 0, 4'b0010, 0, 1, 0, 0, 2};
        tbl[13] = '{0, 1, 0, 4'b0010, 0, 0, 0, 1, 1};
        tbl[14] = '{0, 0, 1, 4'b1000, 1, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 4'b1000, 0, 0, 0, 0, 3};
        tbl[16] = '{0, 0, 1, 4'b0000, 1, 0, 0, 0, 3};
        tbl[17] = '{0, 0, 1, 4'b0000, 1, 0, 0, 0, 3};
        tbl[18] = '{0, 0, 0, 4'b0001, 0, 1, 0, 0, 3};
        tbl[19] = '{0, 0, 0, 4'b0001, 0, 0, 0, 0, 3};
        tbl[20] = '{0, 1, 0, 4'b0001, 0, 0, 0, 1, 0};
        tbl[21] = '{0, 1, 1, 4'b0000, 0, 0, 0, 1, 0};

        for (int k = 0; k < 2; k++) begin
            m_armed[k] = 1'b0;
            m_sel[k]   = 0;
            m_sat[k]   = 1'b0;
            m_ack[k]   = 1'b0;
            m_rej[k]   = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
        end

        reset = 1'b1;
        a.mode = 1'b0; a.ballot_enable = 1'b0; a.cand_vote = 4'b0000;
        b.mode = 1'b0; b.ballot_enable = 1'b0; b.cand_vote = 4'b0000;
        @(posedge clock);
        #1;

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].rst, tbl[i].mode, tbl[i].be, tbl[i].cv);
            chk($sformatf("tbl%0d.ballot_ready", i), a.ballot_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d.vote_ack", i), a.vote_ack, tbl[i].ack);
            chk($sformatf("tbl%0d.vote_reject", i), a.vote_reject, tbl[i].rej);
            chk($sformatf("tbl%0d.disp", i), int'(a.disp), tbl[i].disp);
            chk($sformatf("tbl%0d.disp_sel", i), int'(a.disp_sel), tbl[i].sel);
        end

        // Saturation: the fourth vote on a 2-bit counter still acknowledges.
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int v = 0; v < 4; v++) vote(4'b1000);
        chk("sat.vote4_ack", b.vote_ack, 1);
        cycle(1'b0, 1'b1, 1'b0, 4'b1000);
        chk("sat.b_disp", int'(b.disp), 3);
        chk("sat.b_flag", b.sat_flag, 1);
        chk("sat.a_disp", int'(a.disp), 4);
        chk("sat.a_flag", a.sat_flag, 0);

        // Reset in the middle of an armed ballot clears everything.
        cycle(1'b0, 1'b0, 1'b0, 4'b0000);
        for (int v = 0; v < 5; v++) vote(4'b0001);
        cycle(1'b0, 1'b1, 1'b0, 4'b0001);
        chk("acc.a_count0", int'(a.disp), 5);
        cycle(1'b0, 1'b0, 1'b1, 4'b0000);
        chk("rst.armed_before", a.ballot_ready, 1);
        cycle(1'b1, 1'b0, 1'b0, 4'b0001);
        chk("rst.ballot_ready", a.ballot_ready, 0);
        chk("rst.b_sat", b.sat_flag, 0);
        cycle(1'b0, 1'b1, 1'b0, 4'b0000);
        chk("rst.a_disp", int'(a.disp), 0);
        chk("rst.a_disp_sel", int'(a.disp_sel), 0);

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      cv = 4'b0000;
            else if (r == 3) cv = 4'($urandom_range(0, 15));
            else             cv = 4'b0001 << $urandom_range(0, 3);
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, cv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
